// File: rtl/pc_flag_unit_pkg.sv
// Shared fetch/branch definitions: opcodes, condition codes, flag bit positions
// and the control-stage FSM encoding. Also imported by the ALU and decoder.
package pc_flag_unit_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } ccc_e;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pc_flag_unit_cond_eval.sv
// Branch condition evaluator: decides whether a ccc code holds for a given
// N/Z/V flag set. Purely combinational so later pipeline stages can reuse it.
module pc_flag_unit_cond_eval
  import pc_flag_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, z, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  // NOTE: a default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    taken = 1'b0;
    case (ccc_e'(ccc))
      CC_NE:   taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || (!z && !n);
      CC_LE:   taken = n || z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// Fetch-side control stage: owns the PC, the architectural N/Z/V flags and the
// run/halt state, and resolves B/BR against the flags left by earlier instructions.
module pc_flag_unit
  import pc_flag_unit_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [3:0]        opcode,
  input  logic [2:0]        ccc,
  input  logic [8:0]        imm9,
  input  logic [DATA_W-1:0] br_target,
  input  logic [2:0]        alu_flags,
  input  logic [2:0]        alu_flag_en,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus2,
  output logic [2:0]        flags_q,
  output logic              branch_taken,
  output logic              halted
);

  state_e            state;
  logic              cond_true;
  logic              is_branch;
  logic              is_hlt;
  logic              advance;
  logic [DATA_W-1:0] b_offset;
  logic [DATA_W-1:0] next_pc;

  pc_flag_unit_cond_eval u_cond_eval (
    .ccc   (ccc),
    .flags (flags_q),
    .taken (cond_true)
  );

  assign is_branch    = (opcode == OP_B) || (opcode == OP_BR);
  assign is_hlt       = (opcode == OP_HLT);
  assign advance      = (state == ST_RUN) && !stall;
  assign branch_taken = is_branch && cond_true && (state == ST_RUN);
  assign pc_plus2     = pc + DATA_W'(2);

  // Offset counts instructions: sign-extend imm9, then scale by two bytes.
  assign b_offset = {{(DATA_W-9){imm9[8]}}, imm9[7:0], 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (is_hlt)
      next_pc = pc;
    else if (branch_taken && opcode == OP_B)
      next_pc = pc_plus2 + b_offset;
    else if (branch_taken && opcode == OP_BR)
      next_pc = {br_target[DATA_W-1:1], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      flags_q <= 3'b000;
      state   <= ST_RUN;
      halted  <= 1'b0;
    end else if (advance) begin
      pc <= next_pc;
      if (is_hlt) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (alu_flag_en[i]) flags_q[i] <= alu_flags[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed bench for pc_flag_unit: a vector table walks PC sequencing, flag
// writes and every condition code; hand sequences cover halt, stall and reset.
module tb_pc_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] br_target;
  logic [2:0]  alu_flags;
  logic [2:0]  alu_flag_en;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [2:0]  flags_q;
  logic        branch_taken;
  logic        halted;

  int total = 0;
  int bad   = 0;

  pc_flag_unit #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .opcode       (opcode),
    .ccc          (ccc),
    .imm9         (imm9),
    .br_target    (br_target),
    .alu_flags    (alu_flags),
    .alu_flag_en  (alu_flag_en),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flags_q      (flags_q),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [3:0]  op;
    logic [2:0]  ccc;
    logic [8:0]  imm;
    logic [15:0] tgt;
    logic [2:0]  af;
    logic [2:0]  en;
    logic        exp_taken;
    logic [15:0] exp_pc;
    logic [2:0]  exp_flags;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic [3:0] op, input logic [2:0] c,
                     input logic [8:0] im, input logic [15:0] tg, input logic [2:0] af,
                     input logic [2:0] en, input logic tk, input logic [15:0] epc,
                     input logic [2:0] efl);
    vec_t v;
    v = '{st, op, c, im, tg, af, en, tk, epc, efl, 1'b0};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [2:0] c,
                       input logic [8:0] im, input logic [15:0] tg,
                       input logic [2:0] af, input logic [2:0] en);
    stall = st; opcode = op; ccc = c; imm9 = im; br_target = tg;
    alu_flags = af; alu_flag_en = en;
  endtask

  initial begin
    logic [15:0] cur_pc;

    //  stall op    ccc   imm     tgt       af      en      tk    pc        flags
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0002, 3'b000);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0004, 3'b000);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0006, 3'b000);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0008, 3'b000);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b101, 3'b111, 1'b0, 16'h000A, 3'b101);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b010, 3'b010, 1'b0, 16'h000C, 3'b111);
    add(0, 4'hD, 3'd7, 9'h000, 16'h0011, 3'b010, 3'b111, 1'b1, 16'h0010, 3'b010);
    add(0, 4'hC, 3'd1, 9'h1FE, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h000E, 3'b010);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0010, 3'b010);
    add(0, 4'hC, 3'd0, 9'h1FE, 16'h0000, 3'b000, 3'b111, 1'b0, 16'h0012, 3'b000);
    add(0, 4'hC, 3'd0, 9'h002, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h0018, 3'b000);
    add(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b100, 3'b111, 1'b0, 16'h001A, 3'b100);
    add(0, 4'hC, 3'd3, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h001C, 3'b100);
    add(0, 4'hC, 3'd2, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h001E, 3'b100);
    add(0, 4'hC, 3'd5, 9'h1FF, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h001E, 3'b100);
    add(0, 4'hC, 3'd4, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0020, 3'b100);
    add(0, 4'hC, 3'd6, 9'h000, 16'h0000, 3'b001, 3'b001, 1'b0, 16'h0022, 3'b101);
    add(0, 4'hC, 3'd6, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h0024, 3'b101);
    add(1, 4'hC, 3'd7, 9'h010, 16'h0000, 3'b010, 3'b111, 1'b1, 16'h0024, 3'b101);
    add(1, 4'hC, 3'd7, 9'h010, 16'h0000, 3'b010, 3'b111, 1'b1, 16'h0024, 3'b101);
    add(1, 4'hC, 3'd7, 9'h010, 16'h0000, 3'b010, 3'b111, 1'b1, 16'h0024, 3'b101);
    add(0, 4'hC, 3'd7, 9'h010, 16'h0000, 3'b010, 3'b111, 1'b1, 16'h0046, 3'b010);
    add(0, 4'hD, 3'd7, 9'h000, 16'hFFFE, 3'b000, 3'b000, 1'b1, 16'hFFFE, 3'b010);
    add(0, 4'hC, 3'd7, 9'h001, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h0002, 3'b010);
    add(0, 4'hE, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0004, 3'b010);
    add(1, 4'hF, 3'd0, 9'h000, 16'h0000, 3'b101, 3'b111, 1'b0, 16'h0004, 3'b010);
    add(0, 4'hD, 3'd0, 9'h000, 16'h0100, 3'b000, 3'b000, 1'b0, 16'h0006, 3'b010);
    add(0, 4'hD, 3'd1, 9'h000, 16'h0021, 3'b000, 3'b000, 1'b1, 16'h0020, 3'b010);

    rst = 1'b1;
    drive(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000);
    #12;
    check("reset_pc", 32'(pc), 32'h0000);
    check("reset_flags", 32'(flags_q), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    cur_pc = 16'h0000;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].op, vecs[i].ccc, vecs[i].imm, vecs[i].tgt,
            vecs[i].af, vecs[i].en);
      #1;
      check($sformatf("v%0d_taken", i), 32'(branch_taken), 32'(vecs[i].exp_taken));
      check($sformatf("v%0d_pc_plus2", i), 32'(pc_plus2), 32'(16'(cur_pc + 16'd2)));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      check($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vecs[i].exp_flags));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      cur_pc = vecs[i].exp_pc;
    end

    // HLT at 0x0020 with ALU flag enables active: flags must not be written.
    drive(0, 4'hF, 3'd7, 9'h000, 16'h0000, 3'b101, 3'b111);
    #1;
    check("hlt_taken", 32'(branch_taken), 32'h0);
    @(posedge clk);
    #1;
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_pc", 32'(pc), 32'h0020);
    check("hlt_flags", 32'(flags_q), 32'h2);

    for (int k = 0; k < 10; k++) begin
      drive(1'(k % 2), (k < 5) ? 4'hC : 4'h0, 3'd7, 9'h010, 16'h1234, 3'b101, 3'b111);
      #1;
      check($sformatf("halt%0d_taken", k), 32'(branch_taken), 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("halt%0d_pc", k), 32'(pc), 32'h0020);
      check($sformatf("halt%0d_halted", k), 32'(halted), 32'h1);
      check($sformatf("halt%0d_flags", k), 32'(flags_q), 32'h2);
    end

    // Reset asserted mid-cycle while halted acts immediately.
    #2;
    rst = 1'b1;
    #1;
    check("rst_halt_pc", 32'(pc), 32'h0000);
    check("rst_halt_halted", 32'(halted), 32'h0);
    check("rst_halt_flags", 32'(flags_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000);
    @(posedge clk);
    #1;
    check("resume_pc", 32'(pc), 32'h0002);
    check("resume_halted", 32'(halted), 32'h0);

    // Reset asserted mid-stall.
    drive(1, 4'hC, 3'd7, 9'h004, 16'h0000, 3'b111, 3'b111);
    @(posedge clk);
    #1;
    check("stall_hold_pc", 32'(pc), 32'h0002);
    #2;
    rst = 1'b1;
    #1;
    check("rst_stall_pc", 32'(pc), 32'h0000);
    check("rst_stall_flags", 32'(flags_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 4'h0, 3'd0, 9'h000, 16'h0000, 3'b000, 3'b000);
    @(posedge clk);
    #1;
    check("resume2_pc", 32'(pc), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
- Fetch-side control stage that owns the program counter and the architectural N/Z/V flag register.
- Consumes the ALU's flags/enable outputs at the end of each instruction.
- Resolves conditional branches (B, BR) against the registered flags and produces the next PC.
- Implements the HLT state machine; sits directly downstream of the ALU flag outputs and upstream of instruction fetch.

Parameters:
- DATA_W, 16, width of PC, branch register target and PC arithmetic.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  freeze: PC, flags and FSM hold their values.
- opcode  input  4  opcode of the instruction currently executing.
- ccc  input  3  branch condition code, instr[11:9].
- imm9  input  9  signed branch offset in instructions, instr[8:0].
- br_target  input  DATA_W  register-sourced target for BR.
- alu_flags  input  3  ALU flags, bit order [2]=N [1]=Z [0]=V.
- alu_flag_en  input  3  per-bit flag write enable from the ALU, same bit order.
- pc  output  DATA_W  current PC, the fetch address.
- pc_plus2  output  DATA_W  pc + 2, used by PCS writeback.
- flags_q  output  3  registered N/Z/V.
- branch_taken  output  1  the current B/BR instruction redirects the PC.
- halted  output  1  processor halted (sticky).

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately): pc=RESET_PC, flags_q=3'b000, halted=0, FSM=RUN.
- FSM states:
  - RUN: normal execution.
  - HALTED: terminal; left only via rst.
- Opcode constants: B=4'hC, BR=4'hD, PCS=4'hE, HLT=4'hF. All other opcodes are sequential.
- Flag register, written at the rising edge when state=RUN, stall=0 and opcode != HLT:
  - For each i, flags_q[i] <= alu_flags[i] if alu_flag_en[i]; otherwise flags_q[i] holds.
  - Partial enables (e.g. 3'b010 from XOR/shift ops) update only Z; N and V keep their old values.
- Condition evaluation is combinational on flags_q, i.e. the flags left by earlier instructions, never the current cycle's alu_flags:
  - 000 NE: Z==0.
  - 001 EQ: Z==1.
  - 010 GT: Z==0 and N==0.
  - 011 LT: N==1.
  - 100 GE: Z==1, or Z==0 and N==0.
  - 101 LE: N==1 or Z==1.
  - 110 OV: V==1.
  - 111 UN: always true.
- branch_taken = (opcode is B or BR) and cond true and state==RUN. It is combinational, with zero-cycle latency.
- Next-PC selection:
  - B taken: pc_plus2 + (sign_extend(imm9) << 1).
  - BR taken: br_target with bit 0 forced to 0.
  - HLT: pc (hold).
  - Otherwise: pc_plus2.
- PC arithmetic is modulo 2^DATA_W: 16'hFFFE + 2 wraps to 16'h0000, and negative offsets wrap the same way. Overflow is not flagged.
- pc updates at the rising edge only when state=RUN and stall=0.
- HLT in RUN with stall=0:
  - Next edge: state=HALTED, halted=1, pc stays at the HLT's address.
  - Flags are not written.
- HALTED:
  - pc and flags_q frozen; halted=1.
  - branch_taken=0; all inputs ignored.
- stall=1 overrides everything except rst: no PC, flag or FSM update. branch_taken is still evaluated so downstream can observe it.
- A flag-setting ALU op immediately followed by a branch: the branch sees the new flags, because they are registered at the intervening edge.
- rst asserted mid-halt or mid-stall: immediate return to reset values.
- Execution resumes in RUN at RESET_PC on the first edge after rst deasserts.

Decomposition:
- Shared package (also used by the ALU and decoder):
  - Opcode constants B/BR/PCS/HLT.
  - ccc encodings NE..UN.
  - Flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0.
  - FSM state encoding RUN/HALTED.
- One sub-module, cond_eval: combinational (ccc, flags) -> taken. It is reused by any later pipelined branch-resolution stage.

Test Plan:
- Reset release, 4 non-branch opcodes (e.g. 4'h0), no stall -> pc sequence 0,2,4,6,8; flags_q=000 until alu_flag_en is nonzero.
- Write sequence:
  - alu_flags=3'b101, en=111 -> flags_q=101.
  - Then alu_flags=3'b010, en=010 -> flags_q=111: N and V held, only Z written.
- Branch tests:
  - flags_q=010, B ccc=001, pc=16'h0010, imm9=9'h1FE (-2) -> branch_taken=1, next pc=16'h000E.
  - Same instruction with ccc=000 -> taken=0, next pc=16'h0012.
- BR ccc=111, br_target=16'h1235 -> next pc=16'h1234.
- Wrap: pc=16'hFFFE, B ccc=111, imm9=9'h001 -> next pc=16'h0002.
- HLT, stall, reset:
  - HLT at pc=16'h0020 -> halted=1 next edge; pc stays 16'h0020 for 10 cycles despite B/ALU inputs.
  - stall=1 for 3 cycles on a taken B -> pc unchanged.
  - rst pulsed mid-cycle -> pc=0 and halted=0 immediately.
